// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction-format enum and parameter legality
// helpers for the RV32I decode / register-file stage.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit nreg_legal(input int nreg);
        return (nreg == 32) || (nreg == 16);
    endfunction

endpackage

// File: rtl/decode_regfile_imm_gen.sv
// Combinational format classifier and immediate generator: maps a raw
// instruction word to its base format and XLEN-wide sign-extended immediate.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    output fmt_e             fmt_o,
    output logic [XLEN-1:0]  imme_o
);

    logic [31:0] imm32;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        fmt_o = FMT_NONE;
        imm32 = '0;
        case (instr[6:0])
            OP_R: fmt_o = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: begin
                fmt_o = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt_o = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_o = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_o = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // A signed size cast replicates bit 31 up to XLEN.
    assign imme_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_regfile.sv
// RV32I decode + register-file stage with a registered valid/ready output slot.
// Optional DECODE_BYPASS_EN forwards same-cycle write-back into reads and held operands.
module decode_regfile
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_i,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imme_o,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    localparam int AW = $clog2(NREG);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("decode_regfile: XLEN must be 32 or 64");
    end
    if (!nreg_legal(NREG)) begin : g_bad_nreg
        $error("decode_regfile: NREG must be 32 or 16");
    end

    logic [XLEN-1:0] regs [NREG];
    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_illegal;
    logic [XLEN-1:0] op1, op2;
    logic            wr_ok, accept;

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < 32'(NREG);
    endfunction

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr  (instr_i),
        .fmt_o  (dec_fmt),
        .imme_o (dec_imm)
    );

    // Only fields the format actually uses are reported; the rest read as x0.
    always_comb begin
        dec_rs1 = '0;
        dec_rs2 = '0;
        dec_rd  = '0;
        case (dec_fmt)
            FMT_R:        begin dec_rs1 = instr_i[19:15]; dec_rs2 = instr_i[24:20]; dec_rd = instr_i[11:7]; end
            FMT_I:        begin dec_rs1 = instr_i[19:15]; dec_rd = instr_i[11:7]; end
            FMT_S, FMT_B: begin dec_rs1 = instr_i[19:15]; dec_rs2 = instr_i[24:20]; end
            FMT_U, FMT_J: dec_rd = instr_i[11:7];
            default: ;
        endcase
        dec_illegal = (dec_fmt == FMT_NONE) || !idx_ok(dec_rs1) || !idx_ok(dec_rs2) || !idx_ok(dec_rd);
    end

    assign wr_ok    = wr_en && (wr_addr != 5'd0) && idx_ok(wr_addr);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
        if (idx == 5'd0 || !idx_ok(idx)) return '0;
`ifdef DECODE_BYPASS_EN
        if (wr_ok && wr_addr == idx) return wr_data;
`endif
        return regs[idx[AW-1:0]];
    endfunction

    always_comb begin
        op1 = read_port(dec_rs1);
        op2 = read_port(dec_rs2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is cleared in reset because architectural state must read 0 after reset, not X.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
            out_valid <= 1'b0;
            imme_o    <= '0;
            rdata1    <= '0;
            rdata2    <= '0;
            rs1_o     <= '0;
            rs2_o     <= '0;
            rd_o      <= '0;
            fmt_o     <= FMT_NONE;
            illegal_o <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            imme_o    <= dec_imm;
            rdata1    <= op1;
            rdata2    <= op2;
            rs1_o     <= dec_rs1;
            rs2_o     <= dec_rs2;
            rd_o      <= dec_rd;
            fmt_o     <= dec_fmt;
            illegal_o <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
`ifdef DECODE_BYPASS_EN
        // Stalled slot: keep held operands coherent with write-back.
        else if (out_valid && wr_ok) begin
            if (rs1_o == wr_addr) rdata1 <= wr_data;
            if (rs2_o == wr_addr) rdata2 <= wr_data;
        end
`endif
    end

endmodule

// File: doc/decode_regfile.md
# decode_regfile

Parametrised instruction-decode and register-file stage for the RV32I core. It accepts one 32-bit instruction per handshake, extracts the register indices and the sign-extended immediate for every base format, and reads two operands from an NREG-entry register file. The results are presented in a registered output slot with valid/ready flow control. It sits between instruction fetch and the ALU/execute stage, and takes its register write-back from the end of the pipeline.

## Interface
- XLEN, 32: datapath width. Legal values are 32 and 64. Immediates are sign-extended to XLEN.
- NREG, 32: register count. Legal values are 32 (RV32I) and 16 (RV32E).
- AW, $clog2(NREG): register-index width. This is a derived localparam, not overridable.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instr_i is valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- instr_i  in  32  instruction word.
- wr_en  in  1  register write-back enable.
- wr_addr  in  5  write-back index.
- wr_data  in  XLEN  write-back data.
- out_valid  out  1  output slot holds a decoded instruction.
- out_ready  in  1  downstream consumes the slot.
- imme_o  out  XLEN  signed immediate.
- rdata1, rdata2  out  XLEN  operand values.
- rs1_o, rs2_o, rd_o  out  5  decoded indices. An index is 0 when the format does not use it.
- fmt_o  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none.
- illegal_o  out  1  unknown opcode, or an index ≥ NREG.

## Operation
- Opcode-to-format mapping:
  - R: 0110011.
  - I: 0010011, 0000011 (load), 1100111 (JALR).
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111 (AUIPC).
  - J: 1101111.
  - Any other opcode: fmt 7, illegal_o=1, all indices 0, imme_o 0.
- Immediates follow the RV32I bit layout and are sign-extended from instr_i[31].
  - R-format immediate is 0.
  - U-format immediate is {instr[31:12], 12'b0}, then sign-extended to XLEN.
- Accept condition: in_valid && in_ready, with in_ready = !out_valid || out_ready.
  - On accept, every output register loads the decode result and out_valid becomes 1.
  - On out_ready with no accept, out_valid becomes 0 and the data outputs hold their values.
- Register reads: rdata1/rdata2 = reg[rs1]/reg[rs2], sampled at accept. Index 0 always reads 0.
- Register writes: on wr_en, reg[wr_addr] <= wr_data.
  - Writes with wr_addr = 0 are ignored.
  - Writes with wr_addr ≥ NREG are ignored.
- Out-of-range index (NREG=16, any used index bit 4 set):
  - illegal_o=1.
  - The offending index is still reported on rs*_o/rd_o.
  - Its rdata reads 0.
- Writes are independent of the handshake and proceed during stalls.

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction per cycle while out_ready=1.
- Reset (asynchronous assert, synchronous release):
  - All register-file entries go to 0.
  - out_valid=0, imme_o=0, rdata1=rdata2=0, rs1_o=rs2_o=rd_o=0, fmt_o=7, illegal_o=0.
- in_ready is combinational from out_valid and out_ready, and is 1 during the first cycle after reset.
- Read/write in the same cycle without DECODE_BYPASS_EN: the read returns the old value.
- A reset asserted mid-stall discards the held instruction and does not assert out_valid afterwards.

## Configuration
- DECODE_BYPASS_EN defined:
  - On accept, an rs index equal to a same-cycle nonzero wr_addr with wr_en=1 returns wr_data.
  - While out_valid=1 and out_ready=0, a write matching a held nonzero rs1_o/rs2_o updates the corresponding held rdata1/rdata2 in that cycle, so a stalled slot never holds stale operands.
- DECODE_BYPASS_EN undefined:
  - Reads always return the pre-write array contents.
  - Held operands never change during a stall.
  - Hazard resolution is the responsibility of the pipeline control.

## Structure
- Package decode_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - the fmt_e enum (R, I, S, B, U, J, NONE=7);
  - XLEN legality checks.
- Sub-module imm_gen is purely combinational: instr[31:0] -> fmt_o, imme_o.
- The register array, bypass muxes and output slot live in decode_regfile.

## Test plan
- Reset with no stimulus -> out_valid=0, in_ready=1, every register reads 0.
- Write x5=0x0000_1234, then accept addi x6,x5,-1 (0xFFF28313) -> next cycle fmt_o=1, rs1_o=5, rd_o=6, imme_o=0xFFFF_FFFF, rdata1=0x1234.
- Accept B-type 0xFE000EE3 (beq x0,x0,-4) -> imme_o=0xFFFF_FFFC, fmt_o=3. Accept J-type 0x0080006F -> imme_o=8, fmt_o=5.
- Back-to-back accepts with out_ready=0 on the second cycle -> in_ready=0, the first slot holds; release out_ready -> the second instruction appears one cycle later, with no drop and no duplicate.
- With DECODE_BYPASS_EN, write x7=0xDEAD_BEEF in the same cycle as accepting add x1,x7,x7 -> rdata1=rdata2=0xDEAD_BEEF. Without the macro -> both read the old x7.
- NREG=16, accept add x17,x1,x2 -> illegal_o=1, rd_o=17. Then a write to x0 followed by a read of x0 -> 0.
